run_sequencer: RTL
==================

Name: run_sequencer

Overview:
- Harness-side sequencer directly upstream of the CPU core. It owns the core's reset and the data-memory load/dump port.
- Operation: streams a byte image into data memory, releases the core, and counts cycles until the core asserts done or a timeout expires. It then re-freezes the core and streams a result window out of data memory.
- It replaces ad-hoc testbench memory pokes with a synthesizable, handshaked run controller.

Parameters:
- AW, 8: data-memory address width.
- LOAD_BASE, 0: first address written during load.
- LOAD_LEN, 64: bytes accepted in LOAD (0 allowed).
- DUMP_BASE, 64: first address read during dump.
- DUMP_LEN, 16: bytes emitted in DUMP (0 allowed).
- CW, 16: cycle-counter width.
- MAX_CYCLES, 16'hFFFF: RUN cycle limit before timeout (1..2^CW-1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- start  in  1  begin a load/run/dump sequence; sampled only in IDLE or FINISH.
- ldValid  in  1  load byte valid.
- ldData  in  8  load byte.
- ldReady  out  1  sequencer accepts a load byte.
- memSel  out  1  1 = sequencer drives the data-memory port; 0 = core drives it.
- memAddr  out  AW  data-memory address.
- memWrData  out  8  data-memory write data.
- memWe  out  1  data-memory write enable.
- memRdData  in  8  data-memory read data (combinational read).
- coreReset  out  1  active-high reset to the core.
- coreDone  in  1  core done flag.
- dumpValid  out  1  dump byte valid.
- dumpData  out  8  dump byte.
- dumpReady  in  1  consumer accepts the dump byte.
- cycleCount  out  CW  RUN cycles elapsed.
- busy  out  1  in LOAD, RUN or DUMP.
- timeout  out  1  last run hit MAX_CYCLES.
- finished  out  1  sequence complete.

Behaviour:
- States: IDLE, LOAD, RUN, DUMP, FINISH. An index counter is sized to cover max(LOAD_LEN, DUMP_LEN).
- Reset asserted (reset=0), any state, including mid-operation:
  - State goes to IDLE and the index clears.
  - Outputs: coreReset=1, memSel=0, memWe=0, memAddr=0, memWrData=0, ldReady=0, dumpValid=0, dumpData=0, cycleCount=0, busy=0, timeout=0, finished=0.
- IDLE:
  - coreReset=1; all handshakes deasserted.
  - start=1 moves to LOAD and sets idx=0.
- LOAD:
  - memSel=1, ldReady=1, coreReset=1.
  - A beat is ldValid&ldReady. On a beat, in the same cycle and combinationally: memWe=1, memAddr=(LOAD_BASE+idx) mod 2^AW, memWrData=ldData; idx increments at the clock edge.
  - The beat with idx==LOAD_LEN-1 moves to RUN.
  - If LOAD_LEN==0, LOAD lasts one cycle with ldReady=0, then moves to RUN.
  - With no beat, memWe=0.
- RUN:
  - coreReset=0 and memSel=0 from the first RUN cycle. cycleCount is cleared on the LOAD→RUN edge.
  - Each RUN cycle, cycleCount increments at the clock edge, so done observed in the Nth RUN cycle leaves cycleCount=N.
  - coreDone=1 moves to DUMP with idx=0.
  - Otherwise, when cycleCount==MAX_CYCLES-1 and coreDone=0, the sequencer sets timeout=1, cycleCount becomes MAX_CYCLES, and it moves to DUMP.
  - coreDone and timeout in the same cycle: done wins and timeout stays 0.
  - coreDone is ignored in every state except RUN.
- DUMP:
  - coreReset=1 (core frozen), memSel=1, memWe=0.
  - memAddr=(DUMP_BASE+idx) mod 2^AW; dumpValid=1; dumpData=memRdData.
  - dumpValid stays high and data stays stable until dumpReady=1. Each beat increments idx.
  - The beat with idx==DUMP_LEN-1 moves to FINISH. If DUMP_LEN==0, DUMP moves to FINISH after one cycle with dumpValid=0.
  - dumpData=0 whenever dumpValid=0.
- FINISH:
  - finished=1, busy=0, coreReset=1.
  - cycleCount and timeout are held.
  - start=1 clears finished and timeout, moves to LOAD and sets idx=0.
- busy=1 exactly in LOAD, RUN and DUMP.
- start outside IDLE/FINISH is ignored.
- ldValid outside LOAD is ignored (ldReady=0).
- dumpReady while dumpValid=0 is ignored.
- Address arithmetic wraps modulo 2^AW; LOAD_BASE+LOAD_LEN overflowing wraps to address 0.

Test Plan:
- Assert reset=0 mid-LOAD after 3 beats, then release → IDLE; coreReset=1; ldReady=0; all other outputs 0. A new start reloads from LOAD_BASE.
- LOAD_LEN=4, bytes 11,22,33,44 sent with ldValid gaps → memWe pulses only on beats at addresses 0,1,2,3. RUN entered on the cycle after the 4th beat.
- RUN with coreDone raised in the 7th RUN cycle → cycleCount=7; timeout=0; coreReset goes 1 on entering DUMP.
- MAX_CYCLES=20, coreDone never raised → timeout=1; cycleCount=20; DUMP still executes fully.
- DUMP_BASE=64, DUMP_LEN=3, mem[64..66]=A5,5A,FF, dumpReady toggling 1,0,0,1,1 → bytes A5,5A,FF emitted in order, each held stable while stalled; finished=1 after the 3rd beat.
- LOAD_BASE=254, LOAD_LEN=4 → writes to 254,255,0,1. A start pulse during RUN has no effect.

Source files
------------

// File: rtl/run_sequencer.sv
// Run controller in front of the CPU core: loads a byte image into data memory,
// releases the core until done or timeout, then streams a result window back out.
module run_sequencer #(
  parameter int unsigned AW         = 8,
  parameter int unsigned LOAD_BASE  = 0,
  parameter int unsigned LOAD_LEN   = 64,
  parameter int unsigned DUMP_BASE  = 64,
  parameter int unsigned DUMP_LEN   = 16,
  parameter int unsigned CW         = 16,
  parameter int unsigned MAX_CYCLES = 16'hFFFF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          ldValid,
  input  logic [7:0]    ldData,
  output logic          ldReady,
  output logic          memSel,
  output logic [AW-1:0] memAddr,
  output logic [7:0]    memWrData,
  output logic          memWe,
  input  logic [7:0]    memRdData,
  output logic          coreReset,
  input  logic          coreDone,
  output logic          dumpValid,
  output logic [7:0]    dumpData,
  input  logic          dumpReady,
  output logic [CW-1:0] cycleCount,
  output logic          busy,
  output logic          timeout,
  output logic          finished
);

  localparam int unsigned MAX_LEN = (LOAD_LEN > DUMP_LEN) ? LOAD_LEN : DUMP_LEN;
  localparam int unsigned IW      = (MAX_LEN < 2) ? 1 : $clog2(MAX_LEN);

  localparam logic [IW-1:0] LOAD_LAST = IW'((LOAD_LEN == 0) ? 0 : LOAD_LEN - 1);
  localparam logic [IW-1:0] DUMP_LAST = IW'((DUMP_LEN == 0) ? 0 : DUMP_LEN - 1);
  localparam logic [CW-1:0] RUN_LAST  = CW'(MAX_CYCLES - 1);
  localparam logic [AW-1:0] LOAD_A0   = AW'(LOAD_BASE);
  localparam logic [AW-1:0] DUMP_A0   = AW'(DUMP_BASE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DUMP,
    S_FINISH
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cycle_q, cycle_d;
  logic          timeout_q, timeout_d;

  // State and run bookkeeping registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cycle_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cycle_q   <= cycle_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state and memory/handshake port control
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cycle_d   = cycle_q;
    timeout_d = timeout_q;
    ldReady   = 1'b0;
    memSel    = 1'b0;
    memAddr   = '0;
    memWrData = '0;
    memWe     = 1'b0;
    coreReset = 1'b1;
    dumpValid = 1'b0;
    dumpData  = '0;
    busy      = 1'b0;
    finished  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end

      S_LOAD: begin
        busy    = 1'b1;
        memSel  = 1'b1;
        memAddr = LOAD_A0 + AW'(idx_q);
        if (LOAD_LEN == 0) begin
          state_d = S_RUN;
          cycle_d = '0;
        end else begin
          ldReady = 1'b1;
          if (ldValid) begin
            memWe     = 1'b1;
            memWrData = ldData;
            if (idx_q == LOAD_LAST) begin
              state_d = S_RUN;
              idx_d   = '0;
              cycle_d = '0;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end
      end

      S_RUN: begin
        busy      = 1'b1;
        coreReset = 1'b0;
        cycle_d   = cycle_q + CW'(1);
        // Done takes priority over a timeout landing in the same cycle
        if (coreDone) begin
          state_d = S_DUMP;
          idx_d   = '0;
        end else if (cycle_q == RUN_LAST) begin
          state_d   = S_DUMP;
          idx_d     = '0;
          timeout_d = 1'b1;
        end
      end

      S_DUMP: begin
        busy    = 1'b1;
        memSel  = 1'b1;
        memAddr = DUMP_A0 + AW'(idx_q);
        if (DUMP_LEN == 0) begin
          state_d = S_FINISH;
        end else begin
          dumpValid = 1'b1;
          dumpData  = memRdData;
          if (dumpReady) begin
            if (idx_q == DUMP_LAST) begin
              state_d = S_FINISH;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end
      end

      S_FINISH: begin
        finished = 1'b1;
        if (start) begin
          state_d   = S_LOAD;
          idx_d     = '0;
          timeout_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign cycleCount = cycle_q;
  assign timeout    = timeout_q;

endmodule
